mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares a single unified memory port between the core's instruction-fetch path and its load/store path. Used when IMEM and DMEM are merged into one single-port memory: fetch and data accesses are sequenced onto the port one at a time, with round-robin fairness. Read data returns after a fixed memory latency. Only one transaction is outstanding at a time.

## Interface
- `MEM_LAT`, default 1: cycles from read issue to valid `mem_rdata`. Legal range 1..4.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request. Held with `i_addr` stable until `i_gnt`.
- `i_addr` in 32: fetch byte address.
- `i_gnt` out 1: fetch accepted (issue cycle).
- `i_rvalid` out 1: fetch data valid, one-cycle pulse.
- `i_rdata` out 32: fetch data.
- `d_req` in 1: data request. Held with `d_we`, `d_addr`, `d_wdata`, `d_wstrb` stable until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: store byte enables.
- `d_gnt` out 1: data request accepted (issue cycle).
- `d_rvalid` out 1: load data valid, one-cycle pulse. Never asserted for stores.
- `d_rdata` out 32: load data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory byte enables.
- `mem_rdata` in 32: memory read data, valid exactly `MEM_LAT` cycles after a read issue.
- `busy` out 1: a read is outstanding.

## Operation
- **States:**
  - IDLE: no read outstanding.
  - WAIT: read outstanding. Holds `owner` (I/D) and `cnt` (3 bits).
- **Issue-eligible cycle:** state IDLE, or state WAIT with `cnt == MEM_LAT`.
  - In an eligible cycle with any request, issue exactly one request.
  - Issue is combinational: `mem_en`, the selected `*_gnt` and the mem address/data fields are all asserted that cycle.
- **Arbitration:**
  - Only one requester active: it wins.
  - Both active: the requester that is not `last_owner` wins.
  - `last_owner` updates to the winner on every issue.
  - Reset value of `last_owner` is I, so D wins the first conflict after reset.
- **Fetch issue:** `mem_we=0`, `mem_addr=i_addr`, `mem_wstrb=0`, `mem_wdata=0`.
- **Data issue:** `mem_we=d_we`, `mem_addr=d_addr`, `mem_wdata=d_wdata`, `mem_wstrb=d_we ? d_wstrb : 0`.
- **Read issue:** next state WAIT, `owner=winner`, `cnt=1`.
- **Store issue:** complete at issue. Next state IDLE, no response.
- **In WAIT with `cnt < MEM_LAT`:** `cnt` increments. No issue, no grants.
- **In WAIT with `cnt == MEM_LAT`:**
  - Assert `owner`'s `*_rvalid`; `*_rdata = mem_rdata`.
  - Next state follows the issue rules above (back-to-back allowed), else IDLE.
- **Data path:** `i_rdata` and `d_rdata` both carry `mem_rdata` at all times. Only `*_rvalid` qualifies them.
- **Address handling:** addresses pass through unchanged. No alignment checking.
- **`busy`:** `busy = (state == WAIT)`.

## Timing
- **Reset (while `rst` high and on the cycle after):**
  - State IDLE, `cnt=0`, `last_owner=I`.
  - All grant, rvalid, mem_* and `busy` outputs are 0.
- **Reset mid-read:** the outstanding read is dropped and no rvalid is ever produced for it. Reset has priority over all other events.
- **Read latency:** issue at cycle T → rvalid at T+`MEM_LAT`.
- **Read throughput:** one read per `MEM_LAT` cycles. With `MEM_LAT=1`, one per cycle.
- **Store throughput:** one per cycle.
- **Requester rules:**
  - A requester may drop `*_req` only after `*_gnt`.
  - A requester must not assume a grant in the cycle after the request.
- **Simultaneous rvalid and new grant to the same requester:** legal. rvalid refers to the older request.
- **`cnt` width:** `cnt` never exceeds `MEM_LAT`.

## Test plan
- **Single fetch (`MEM_LAT=2`):** `i_req`, `i_addr=0x10` at cycle 0 → cycle 0 shows `i_gnt`, `mem_en`, `mem_addr=0x10`, `mem_we=0`. Memory drives 0x00500093 at cycle 2 → `i_rvalid=1`, `i_rdata=0x00500093` at cycle 2 only. `busy=1` in cycles 1–2.
- **First conflict after reset:** both request at cycle 0 with `MEM_LAT=1` → `d_gnt` at cycle 0, `d_rvalid` and `i_gnt` at cycle 1, `i_rvalid` at cycle 2.
- **Continuous contention (`MEM_LAT=1`, both reading):** grants alternate D, I, D, I on consecutive cycles. Each rvalid follows its grant by one cycle.
- **Store then fetch:** `d_we=1`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`, `d_wstrb=0xF`, with `i_req` pending → cycle 0: `mem_we=1`, `mem_wstrb=0xF`, `d_gnt`. Cycle 1: `i_gnt`. `d_rvalid` never asserted.
- **Reset during WAIT (`MEM_LAT=3`):** read issued at cycle 0, `rst=1` at cycle 1 → no rvalid in cycles 1–4. All outputs 0 at cycle 2. Next conflict is granted to D.
- **Load with partial strobe:** `d_we=0`, `d_wstrb=0x3` → `mem_wstrb=0` at issue. `d_rvalid` after `MEM_LAT` cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store. One read outstanding at a time; read data returns MEM_LAT cycles after issue.
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     r_state;
  owner_t     r_owner;
  owner_t     r_last_owner;
  logic [2:0] r_cnt;

  logic   w_resp;
  logic   w_eligible;
  logic   w_issue;
  owner_t w_winner;
  logic   w_read;

  // Outputs are forced low while rst is held so nothing leaks out before state clears.
  assign w_resp     = !rst && (r_state == S_WAIT) && (r_cnt == LAT);
  assign w_eligible = !rst && ((r_state == S_IDLE) || (r_cnt == LAT));
  assign w_issue    = w_eligible && (i_req || d_req);
  assign w_winner   = (d_req && (!i_req || r_last_owner == OWN_I)) ? OWN_D : OWN_I;
  assign w_read     = (w_winner == OWN_I) || !d_we;

  assign i_gnt    = w_issue && (w_winner == OWN_I);
  assign d_gnt    = w_issue && (w_winner == OWN_D);
  assign i_rvalid = w_resp && (r_owner == OWN_I);
  assign d_rvalid = w_resp && (r_owner == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign busy     = !rst && (r_state == S_WAIT);
  assign mem_en   = w_issue;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_we ? d_wstrb : 4'h0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_I;
      r_last_owner <= OWN_I;
      r_cnt        <= '0;
    end else if (r_state == S_WAIT && r_cnt < LAT) begin
      r_cnt <= r_cnt + 3'd1;
    end else if (w_issue) begin
      r_last_owner <= w_winner;
      if (w_read) begin
        r_state <= S_WAIT;
        r_owner <= w_winner;
        r_cnt   <= 3'd1;
      end else begin
        // Stores complete at issue and never produce a response.
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end
    end else begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// scored against a cycle-indexed transaction model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Packed control view: {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_en, mem_we, mem_wstrb}
  function automatic logic [10:0] ctl();
    return {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_en, mem_we, mem_wstrb};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_addr = 32'h88;
    step();
    @(negedge clk);
    tests++;
    if (ctl() !== 11'b0 || mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_held: ctl=%b addr=%h, want 0/0", ctl(), mem_addr);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    tests++;
    if (ctl() !== 11'b0) begin
      fails++;
      $display("FAIL reset_after: ctl=%b, want 0", ctl());
    end
  endtask

  task automatic test_single_fetch();
    logic [10:0] want [4];
    want = '{11'b10000100000, 11'b00001000000, 11'b00101000000, 11'b00000000000};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin i_req = 1'b1; i_addr = 32'h10; end
      else i_req = 1'b0;
      mem_rdata = (c == 2) ? 32'h00500093 : 32'h0;
      @(negedge clk);
      tests++;
      if (ctl() !== want[c]) begin
        fails++;
        $display("FAIL single_fetch c%0d: ctl=%b, want %b", c, ctl(), want[c]);
      end
      if (c == 0) begin
        tests++;
        if (mem_addr !== 32'h10) begin
          fails++;
          $display("FAIL single_fetch_addr: got %h want 00000010", mem_addr);
        end
      end
      if (c == 2) begin
        tests++;
        if (i_rdata !== 32'h00500093) begin
          fails++;
          $display("FAIL single_fetch_rdata: got %h want 00500093", i_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_first_conflict();
    logic [10:0] want [6];
    want = '{11'b01000100000, 11'b00001000000, 11'b10011100000,
             11'b00001000000, 11'b00101000000, 11'b00000000000};
    apply_reset();
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (ctl() !== want[c]) begin
        fails++;
        $display("FAIL first_conflict c%0d: ctl=%b, want %b", c, ctl(), want[c]);
      end
      if (c == 0 || c == 2) begin
        tests++;
        if (mem_addr !== (c == 0 ? 32'h200 : 32'h400)) begin
          fails++;
          $display("FAIL first_conflict_addr c%0d: got %h", c, mem_addr);
        end
      end
      step();
      if (c == 0) d_req = 1'b0;
      if (c == 2) i_req = 1'b0;
    end
  endtask

  // Runs right after the conflict test, so last owner is I and the store wins.
  task automatic test_store_then_fetch();
    logic [10:0] want [5];
    want = '{11'b01000111111, 11'b10000100000, 11'b00001000000,
             11'b00101000000, 11'b00000000000};
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (ctl() !== want[c]) begin
        fails++;
        $display("FAIL store_fetch c%0d: ctl=%b, want %b", c, ctl(), want[c]);
      end
      if (c == 0) begin
        tests++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
          fails++;
          $display("FAIL store_fields: addr=%h wdata=%h, want 00000100/deadbeef", mem_addr, mem_wdata);
        end
      end
      if (c == 1) begin
        tests++;
        if (mem_addr !== 32'h20 || mem_wdata !== 32'h0) begin
          fails++;
          $display("FAIL fetch_fields: addr=%h wdata=%h, want 00000020/0", mem_addr, mem_wdata);
        end
      end
      step();
      if (c == 0) d_req = 1'b0;
      if (c == 1) i_req = 1'b0;
    end
  endtask

  task automatic test_load_partial_strobe();
    logic [10:0] want [4];
    want = '{11'b01000100000, 11'b00001000000, 11'b00011000000, 11'b00000000000};
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h12345678; d_wstrb = 4'h3;
    for (int c = 0; c < 4; c++) begin
      mem_rdata = (c == 2) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      tests++;
      if (ctl() !== want[c]) begin
        fails++;
        $display("FAIL load_strobe c%0d: ctl=%b, want %b", c, ctl(), want[c]);
      end
      if (c == 2) begin
        tests++;
        if (d_rdata !== 32'hCAFEF00D) begin
          fails++;
          $display("FAIL load_rdata: got %h want cafef00d", d_rdata);
        end
      end
      step();
      d_req = 1'b0;
    end
  endtask

  task automatic test_reset_during_wait();
    apply_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(negedge clk);
    tests++;
    if (d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rst_wait_issue: d_gnt=%b want 1", d_gnt);
    end
    step();
    d_req = 1'b0;
    rst = 1'b1;
    for (int c = 1; c < 5; c++) begin
      mem_rdata = 32'hFFFF0000 + 32'(c);
      @(negedge clk);
      tests++;
      if (ctl() !== 11'b0) begin
        fails++;
        $display("FAIL rst_wait c%0d: ctl=%b, want 0", c, ctl());
      end
      step();
      rst = 1'b0;
    end
    i_req = 1'b1; i_addr = 32'h600;
    d_req = 1'b1; d_addr = 32'h700;
    @(negedge clk);
    tests++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL rst_wait_conflict: {i_gnt,d_gnt}=%b want 01", {i_gnt, d_gnt});
    end
    step();
    idle_inputs();
  endtask

  // Model: a pending read is just the cycle its data is due and who owns it;
  // the port is free when nothing is pending or the pending read is due now.
  task automatic test_random(input int n);
    int   due;
    bit   due_d, last_d, i_took, d_took;
    bit   e_ig, e_dg, resp, elig;
    logic [138:0] got, exp;
    apply_reset();
    due = -1; due_d = 0; last_d = 0; i_took = 0; d_took = 0;
    for (int c = 0; c < n; c++) begin
      if (!i_req || i_took) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = $urandom;
      end
      if (!d_req || d_took) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom);
      end
      mem_rdata = $urandom;
      @(negedge clk);
      resp = (due == c);
      elig = (due < 0) || resp;
      e_ig = elig && i_req && (!d_req || last_d);
      e_dg = elig && d_req && !e_ig;
      exp = {e_ig, e_dg, resp && !due_d, resp && due_d, due >= 0, e_ig || e_dg, e_dg && d_we,
             (e_dg && d_we) ? d_wstrb : 4'h0,
             e_ig ? i_addr : (e_dg ? d_addr : 32'h0),
             e_dg ? d_wdata : 32'h0, mem_rdata, mem_rdata};
      got = {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_en, mem_we, mem_wstrb,
             mem_addr, mem_wdata, i_rdata, d_rdata};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random c%0d: got %h want %h", c, got, exp);
      end
      i_took = e_ig;
      d_took = e_dg;
      if (e_ig || e_dg) begin
        last_d = e_dg;
        if (e_ig || !d_we) begin
          due   = c + LAT;
          due_d = e_dg;
        end else begin
          due = -1;
        end
      end else if (resp) begin
        due = -1;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_first_conflict();
    test_store_then_fetch();
    test_load_partial_strobe();
    test_reset_during_wait();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
